// File: rtl/divider_pkg.sv
// Shared types and helpers for the restoring divider and its optional hex display.
package divider_pkg;

    localparam int unsigned DIV_WIDTH = 8;
    localparam logic [7:0]  SEG_BLANK = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ITER  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } div_state_t;

    // Hex nibble to active-low {dp,g..a}; dp always off.
    function automatic logic [7:0] seg7_f(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Operator/result bundle of the restoring divider: switches and buttons in, results and flags out.
interface restoring_divider_if
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic             Load_Clear;
    logic             Run;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] Qval;
    logic [WIDTH-1:0] Rval;
    logic [WIDTH-1:0] Dval;
    logic             Busy;
    logic             Done;
    logic             Div0;
    logic             Ovf;

    modport master (
        output Load_Clear, Run, SW,
        input  Qval, Rval, Dval, Busy, Done, Div0, Ovf
    );

    modport slave (
        input  Load_Clear, Run, SW,
        output Qval, Rval, Dval, Busy, Done, Div0, Ovf
    );

endinterface

// File: rtl/div_hex_mux.sv
// Four-digit multiplexed hex display scanner; only built with DIVIDER_HEX_EN.
`ifdef DIVIDER_HEX_EN
module div_hex_mux
    import divider_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] value,
    output logic [3:0]  hex_grid,
    output logic [7:0]  hex_seg
);

    logic [REFRESH_BITS+1:0] r_cnt;
    logic [3:0]              r_grid;
    logic [7:0]              r_seg;
    logic [1:0]              w_digit;
    logic [3:0]              w_nib;

    // Top two counter bits pick the digit, so each digit stays lit 2^REFRESH_BITS clocks.
    assign w_digit = r_cnt[REFRESH_BITS+1:REFRESH_BITS];

    always_comb begin
        w_nib = value[3:0];
        case (w_digit)
            2'd0:    w_nib = value[3:0];
            2'd1:    w_nib = value[7:4];
            2'd2:    w_nib = value[11:8];
            default: w_nib = value[15:12];
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt  <= '0;
            r_grid <= 4'hF;
            r_seg  <= SEG_BLANK;
        end else begin
            r_cnt  <= r_cnt + (REFRESH_BITS+2)'(1);
            r_grid <= ~(4'b0001 << w_digit);
            r_seg  <= seg7_f(w_nib);
        end
    end

    assign hex_grid = r_grid;
    assign hex_seg  = r_seg;

endmodule
`endif

// File: rtl/restoring_divider.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Optional hex display of Qval/Rval when DIVIDER_HEX_EN is defined.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
`ifdef DIVIDER_HEX_EN
   ,parameter int unsigned REFRESH_BITS = 16
`endif
) (
    input  logic                Clk,
    input  logic                Reset_n,
    restoring_divider_if.slave  bus
`ifdef DIVIDER_HEX_EN
   ,output logic [3:0]          hex_grid,
    output logic [7:0]          hex_seg
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_d, w_d_nxt;
    logic [WIDTH-1:0] r_n, w_n_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_dabs, w_dabs_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_qval, w_qval_nxt;
    logic [WIDTH-1:0] r_rval, w_rval_nxt;
    logic             r_div0, w_div0_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_dabs_ext;

    // Magnitudes fit WIDTH unsigned bits (|MIN| = 2^(WIDTH-1)); the trial remainder needs one more.
    assign w_rem_sh   = {r_rem, r_q[WIDTH-1]};
    assign w_dabs_ext = {1'b0, r_dabs};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_d     <= '0;
            r_n     <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_dabs  <= '0;
            r_cnt   <= '0;
            r_qval  <= '0;
            r_rval  <= '0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_n     <= w_n_nxt;
            r_q     <= w_q_nxt;
            r_rem   <= w_rem_nxt;
            r_dabs  <= w_dabs_nxt;
            r_cnt   <= w_cnt_nxt;
            r_qval  <= w_qval_nxt;
            r_rval  <= w_rval_nxt;
            r_div0  <= w_div0_nxt;
            r_ovf   <= w_ovf_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_n_nxt     = r_n;
        w_q_nxt     = r_q;
        w_rem_nxt   = r_rem;
        w_dabs_nxt  = r_dabs;
        w_cnt_nxt   = r_cnt;
        w_qval_nxt  = r_qval;
        w_rval_nxt  = r_rval;
        w_div0_nxt  = r_div0;
        w_ovf_nxt   = r_ovf;
        // Status flags follow the state of the previous cycle, so Done rises once results are stable.
        w_busy_nxt  = (r_state == START) || (r_state == ITER) || (r_state == FIX);
        w_done_nxt  = (r_state == DONE);

        case (r_state)
            IDLE: begin
                if (bus.Load_Clear) begin
                    w_d_nxt    = bus.SW;
                    w_qval_nxt = '0;
                    w_rval_nxt = '0;
                    w_div0_nxt = 1'b0;
                    w_ovf_nxt  = 1'b0;
                end else if (bus.Run) begin
                    w_n_nxt     = bus.SW;
                    w_div0_nxt  = 1'b0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_rem_nxt  = '0;
                w_cnt_nxt  = CNT_W'(WIDTH - 1);
                w_q_nxt    = r_n[WIDTH-1] ? WIDTH'(0) - r_n : r_n;
                w_dabs_nxt = r_d[WIDTH-1] ? WIDTH'(0) - r_d : r_d;
                if (r_d == '0) begin
                    w_div0_nxt  = 1'b1;
                    w_qval_nxt  = '1;
                    w_rval_nxt  = r_n;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ITER;
                end
            end
            ITER: begin
                if (w_rem_sh >= w_dabs_ext) begin
                    w_rem_nxt = WIDTH'(w_rem_sh - w_dabs_ext);
                    w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    w_rem_nxt = w_rem_sh[WIDTH-1:0];
                    w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
                end
                if (r_cnt == '0) begin
                    w_state_nxt = FIX;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            FIX: begin
                // MIN/-1 wraps naturally to MIN with remainder 0; only the flag is extra.
                w_qval_nxt  = (r_n[WIDTH-1] ^ r_d[WIDTH-1]) ? WIDTH'(0) - r_q : r_q;
                w_rval_nxt  = r_n[WIDTH-1] ? WIDTH'(0) - r_rem : r_rem;
                w_ovf_nxt   = (r_n == MIN_VAL) && (r_d == '1);
                w_state_nxt = DONE;
            end
            DONE: begin
                if (bus.Load_Clear) begin
                    w_d_nxt    = bus.SW;
                    w_qval_nxt = '0;
                    w_rval_nxt = '0;
                    w_div0_nxt = 1'b0;
                    w_ovf_nxt  = 1'b0;
                end
                if (!bus.Run) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.Qval = r_qval;
    assign bus.Rval = r_rval;
    assign bus.Dval = r_d;
    assign bus.Busy = r_busy;
    assign bus.Done = r_done;
    assign bus.Div0 = r_div0;
    assign bus.Ovf  = r_ovf;

`ifdef DIVIDER_HEX_EN
    if (WIDTH != 8) begin : g_width_chk
        $error("restoring_divider: DIVIDER_HEX_EN needs WIDTH == 8");
    end

    div_hex_mux #(
        .REFRESH_BITS (REFRESH_BITS)
    ) u_hex (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .value    (16'({r_qval, r_rval})),
        .hex_grid (hex_grid),
        .hex_seg  (hex_seg)
    );
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed vector table, corner sequences, random vs model.
module tb_restoring_divider;
    import divider_pkg::*;

    logic Clk;
    logic Reset_n;
    int   n_tests;
    int   n_fail;

    restoring_divider_if #(.WIDTH(8)) bus ();

`ifdef DIVIDER_HEX_EN
    logic [3:0] hex_grid;
    logic [7:0] hex_seg;
    restoring_divider #(.WIDTH(8), .REFRESH_BITS(2)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .bus      (bus),
        .hex_grid (hex_grid),
        .hex_seg  (hex_seg)
    );
`else
    restoring_divider #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] n;
        logic [7:0] q;
        logic [7:0] r;
        logic       div0;
        logic       ovf;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_d(input logic [7:0] d);
        bus.Load_Clear = 1'b1;
        bus.SW         = d;
        @(negedge Clk);
        bus.Load_Clear = 1'b0;
        bus.SW         = 8'($urandom);
        @(negedge Clk);
    endtask

    // Raise Run with the dividend, count negedges until Done, then release and return to IDLE.
    task automatic run_op(input logic [7:0] n, output int lat);
        bus.Run = 1'b1;
        bus.SW  = n;
        lat     = 0;
        do begin
            @(negedge Clk);
            lat++;
            bus.SW = 8'($urandom);
        end while (!bus.Done && lat < 40);
        bus.Run = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic model(input logic [7:0] d, input logic [7:0] n,
                         output logic [7:0] q, output logic [7:0] r, output logic ovf);
        int sn;
        int sd;
        sn = int'($signed(n));
        sd = int'($signed(d));
        ovf = (sn == -128) && (sd == -1);
        q = 8'(sn / sd);
        r = 8'(sn % sd);
    endtask

    initial begin
        vec_t       vecs[$];
        int         lat;
        int         rises;
        logic       prev_done;
        logic [7:0] d, n, eq, er;
        logic       eovf;

        n_tests = 0;
        n_fail  = 0;
        bus.Load_Clear = 1'b0;
        bus.Run        = 1'b0;
        bus.SW         = '0;
        Reset_n        = 1'b0;

        vecs.push_back('{8'd7,  8'd100, 8'h0E, 8'h02, 1'b0, 1'b0, 12});
        vecs.push_back('{8'd7,  8'h9C,  8'hF2, 8'hFE, 1'b0, 1'b0, 12});
        vecs.push_back('{8'hF9, 8'd100, 8'hF2, 8'h02, 1'b0, 1'b0, 12});
        vecs.push_back('{8'hF9, 8'h9C,  8'h0E, 8'hFE, 1'b0, 1'b0, 12});
        vecs.push_back('{8'hFF, 8'h80,  8'h80, 8'h00, 1'b0, 1'b1, 12});
        vecs.push_back('{8'h00, 8'h05,  8'hFF, 8'h05, 1'b1, 1'b0, 3});
        vecs.push_back('{8'h80, 8'h80,  8'h01, 8'h00, 1'b0, 1'b0, 12});
        vecs.push_back('{8'h80, 8'h7F,  8'h00, 8'h7F, 1'b0, 1'b0, 12});
        vecs.push_back('{8'h01, 8'h7F,  8'h7F, 8'h00, 1'b0, 1'b0, 12});
        vecs.push_back('{8'h00, 8'h80,  8'hFF, 8'h80, 1'b1, 1'b0, 3});

        // Reset values
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_qval", 32'(bus.Qval), 32'h0);
        chk("rst_rval", 32'(bus.Rval), 32'h0);
        chk("rst_dval", 32'(bus.Dval), 32'h0);
        chk("rst_busy", 32'(bus.Busy), 32'h0);
        chk("rst_done", 32'(bus.Done), 32'h0);
        chk("rst_div0", 32'(bus.Div0), 32'h0);
        chk("rst_ovf",  32'(bus.Ovf),  32'h0);
`ifdef DIVIDER_HEX_EN
        chk("rst_grid", 32'(hex_grid), 32'hF);
        chk("rst_seg",  32'(hex_seg),  32'hFF);
`endif
        Reset_n = 1'b1;
        @(negedge Clk);

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            load_d(vecs[i].d);
            chk($sformatf("v%0d_dval", i), 32'(bus.Dval), 32'(vecs[i].d));
            run_op(vecs[i].n, lat);
            chk($sformatf("v%0d_lat", i),  32'(lat),      32'(vecs[i].lat));
            chk($sformatf("v%0d_q", i),    32'(bus.Qval), 32'(vecs[i].q));
            chk($sformatf("v%0d_r", i),    32'(bus.Rval), 32'(vecs[i].r));
            chk($sformatf("v%0d_div0", i), 32'(bus.Div0), 32'(vecs[i].div0));
            chk($sformatf("v%0d_ovf", i),  32'(bus.Ovf),  32'(vecs[i].ovf));
        end

        // Async reset in the middle of ITER aborts at once
        load_d(8'd7);
        bus.Run = 1'b1;
        bus.SW  = 8'd100;
        for (int i = 0; i < 5; i++) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.Busy), 32'h0);
        chk("abort_done", 32'(bus.Done), 32'h0);
        chk("abort_qval", 32'(bus.Qval), 32'h0);
        chk("abort_rval", 32'(bus.Rval), 32'h0);
        chk("abort_dval", 32'(bus.Dval), 32'h0);
        bus.Run = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        load_d(8'd7);
        run_op(8'd100, lat);
        chk("rerun_lat", 32'(lat),      32'd12);
        chk("rerun_q",   32'(bus.Qval), 32'h0E);
        chk("rerun_r",   32'(bus.Rval), 32'h02);

        // Run held for 30 cycles gives a single Done rise
        bus.Run   = 1'b1;
        bus.SW    = 8'd50;
        rises     = 0;
        prev_done = bus.Done;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (bus.Done && !prev_done) rises++;
            prev_done = bus.Done;
        end
        chk("hold_rises", 32'(rises),    32'd1);
        chk("hold_q",     32'(bus.Qval), 32'd7);
        bus.Run = 1'b0;
        @(negedge Clk);
        @(negedge Clk);

        // Load_Clear while busy is ignored
        bus.Run = 1'b1;
        bus.SW  = 8'd99;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        bus.Load_Clear = 1'b1;
        bus.SW         = 8'h55;
        @(negedge Clk);
        bus.Load_Clear = 1'b0;
        lat = 0;
        while (!bus.Done && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        chk("busyload_dval", 32'(bus.Dval), 32'd7);
        chk("busyload_q",    32'(bus.Qval), 32'd14);
        chk("busyload_r",    32'(bus.Rval), 32'd1);
        bus.Run = 1'b0;
        @(negedge Clk);
        @(negedge Clk);

        // Run and Load_Clear together in IDLE: load only
        bus.Run        = 1'b1;
        bus.Load_Clear = 1'b1;
        bus.SW         = 8'd9;
        @(negedge Clk);
        bus.Run        = 1'b0;
        bus.Load_Clear = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("both_dval", 32'(bus.Dval), 32'd9);
        chk("both_busy", 32'(bus.Busy), 32'h0);
        chk("both_done", 32'(bus.Done), 32'h0);
        chk("both_qval", 32'(bus.Qval), 32'h0);

        // Random signed pairs against arithmetic model
        for (int i = 0; i < 200; i++) begin
            do d = 8'($urandom); while (d == 8'h00);
            n = (i % 25 == 0) ? 8'h80 : 8'($urandom);
            if (i % 50 == 0) d = 8'hFF;
            model(d, n, eq, er, eovf);
            load_d(d);
            run_op(n, lat);
            chk($sformatf("rnd%0d_lat d=%0h n=%0h", i, d, n), 32'(lat),      32'd12);
            chk($sformatf("rnd%0d_q d=%0h n=%0h", i, d, n),   32'(bus.Qval), 32'(eq));
            chk($sformatf("rnd%0d_r d=%0h n=%0h", i, d, n),   32'(bus.Rval), 32'(er));
            chk($sformatf("rnd%0d_ovf d=%0h n=%0h", i, d, n), 32'(bus.Ovf),  32'(eovf));
        end

`ifdef DIVIDER_HEX_EN
        // Each scanned digit shows the matching nibble of {Qval,Rval}
        for (int k = 0; k < 4; k++) begin
            logic [15:0] val;
            logic [3:0]  nib;
            int          waited;
            val    = {bus.Qval, bus.Rval};
            nib    = 4'(val >> (4 * k));
            waited = 0;
            while (hex_grid != ~(4'b0001 << k) && waited < 64) begin
                @(negedge Clk);
                waited++;
            end
            chk($sformatf("hex_grid%0d", k), 32'(hex_grid), 32'(~(4'b0001 << k)));
            chk($sformatf("hex_seg%0d", k),  32'(hex_seg),  32'(seg7_f(nib)));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
